// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, bit timing and frame levels.
// Both the transmitter and the receiver take their bit period from here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RST_VAL so the output starts at a known level.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, framing error detection.
// Outputs are registered; done/error are single-cycle strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int DATA_BITS = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 rx_en,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_error,
  output logic                 rx_busy
);

  localparam int CLKS_PER_BIT =
    clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF =
    CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 done_d;
  logic                 err_d;

  uart_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .d     (rx_serial),
    .q     (rx_s)
  );

  // next-state, counters, shift register and strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = rx_data;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_en && rx_s == START_BIT)
          state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          if (rx_s == START_BIT)
            state_d = DATA;
          else
            state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST)
            state_d = STOP;
          else
            idx_d = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s == STOP_BIT) begin
            data_d  = sh_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s == STOP_BIT)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
      rx_error <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      rx_data  <= data_d;
      rx_done  <= done_d;
      rx_error <= err_d;
      rx_busy  <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at 100 clocks per bit.
// Frames are serialised by the bench and checked against a frame model.
module tb_uart_rx;

  localparam int CPB = 100;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       rx_en = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_error;
  logic       rx_busy;

  int vectors = 0;
  int miscompares = 0;

  int done_tot = 0;
  int err_tot  = 0;
  int busy_tot = 0;
  int both_tot = 0;

  logic [7:0] model_data;
  int d0, e0, b0, lat;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         en;
    int         gap;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [8];

  uart_rx #(
    .BAUD_RATE (1_000_000),
    .CLK_FREQ  (100_000_000),
    .DATA_BITS (8)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .rx_en     (rx_en),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_error  (rx_error),
    .rx_busy   (rx_busy)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (rx_done) done_tot <= done_tot + 1;
    if (rx_error) err_tot <= err_tot + 1;
    if (rx_busy) busy_tot <= busy_tot + 1;
    if (rx_done && rx_error) both_tot <= both_tot + 1;
  end

  task automatic chk(input string name, input int act,
                     input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input bit stop_ok);
    rx_serial = 1'b0;
    repeat (CPB) @(negedge PCLK);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      repeat (CPB) @(negedge PCLK);
    end
    rx_serial = stop_ok;
    repeat (CPB) @(negedge PCLK);
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge PCLK);
  endtask

  task automatic apply(input logic [7:0] d, input bit stop_ok,
                       input bit en, input int gap,
                       input string tag);
    int dd, de;
    dd = done_tot;
    de = err_tot;
    rx_en = en;
    send_frame(d, stop_ok);
    if (en && stop_ok) model_data = d;
    chk({tag, "_done"}, done_tot - dd, int'(en && stop_ok));
    chk({tag, "_err"}, err_tot - de, int'(en && !stop_ok));
    chk({tag, "_data"}, rx_data, model_data);
    idle(gap);
  endtask

  initial begin
    tbl[0] = '{8'h0F, 1, 1, 200, 1, 0, 8'h0F};
    tbl[1] = '{8'hEE, 1, 1, 200, 1, 0, 8'hEE};
    tbl[2] = '{8'hCD, 1, 1, 200, 1, 0, 8'hCD};
    tbl[3] = '{8'h3C, 0, 1, 200, 0, 1, 8'hCD};
    tbl[4] = '{8'h81, 1, 0, 200, 0, 0, 8'hCD};
    tbl[5] = '{8'h81, 1, 1, 200, 1, 0, 8'h81};
    tbl[6] = '{8'h00, 1, 1, 200, 1, 0, 8'h00};
    tbl[7] = '{8'hFF, 1, 1, 200, 1, 0, 8'hFF};

    repeat (3) @(negedge PCLK);
    chk("rst_data", rx_data, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_err", rx_error, 0);
    chk("rst_busy", rx_busy, 0);
    PRESETn = 1'b1;
    idle(20);
    model_data = 8'h00;

    foreach (tbl[i]) begin
      d0 = done_tot;
      e0 = err_tot;
      b0 = busy_tot;
      rx_en = tbl[i].en;
      send_frame(tbl[i].data, tbl[i].stop_ok);
      chk($sformatf("tbl%0d_done", i),
          done_tot - d0, tbl[i].exp_done);
      chk($sformatf("tbl%0d_err", i),
          err_tot - e0, tbl[i].exp_err);
      chk($sformatf("tbl%0d_data", i),
          rx_data, tbl[i].exp_data);
      if (!tbl[i].en)
        chk($sformatf("tbl%0d_gated_busy", i),
            busy_tot - b0, 0);
      idle(tbl[i].gap);
      chk($sformatf("tbl%0d_idle", i), rx_busy, 0);
    end
    model_data = 8'hFF;
    rx_en = 1'b1;

    d0 = done_tot;
    e0 = err_tot;
    rx_serial = 1'b0;
    repeat (15) @(negedge PCLK);
    chk("glitch_busy_hi", rx_busy, 1);
    repeat (5) @(negedge PCLK);
    idle(100);
    chk("glitch_busy_lo", rx_busy, 0);
    chk("glitch_done", done_tot - d0, 0);
    chk("glitch_err", err_tot - e0, 0);

    send_frame(8'h55, 1'b1);
    chk("b2b_first", rx_data, 8'h55);
    send_frame(8'hA3, 1'b1);
    chk("b2b_second", rx_data, 8'hA3);
    chk("b2b_count", done_tot - d0, 2);
    idle(50);
    model_data = 8'hA3;

    d0 = done_tot;
    e0 = err_tot;
    send_frame(8'h3C, 1'b0);
    repeat (300) @(negedge PCLK);
    chk("brk_busy", rx_busy, 1);
    chk("brk_err", err_tot - e0, 1);
    chk("brk_done", done_tot - d0, 0);
    chk("brk_data", rx_data, model_data);
    idle(10);
    chk("brk_release", rx_busy, 0);
    idle(100);

    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (lat < 2000) begin
          @(posedge PCLK);
          lat++;
          #1;
          if (rx_done) break;
        end
      end
    join
    model_data = 8'hA5;
    chk("lat_lo", int'(lat >= 951), 1);
    chk("lat_hi", int'(lat <= 953), 1);
    chk("lat_data", rx_data, 8'hA5);
    idle(50);

    d0 = done_tot;
    e0 = err_tot;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge PCLK);
    for (int i = 0; i < 4; i++) begin
      rx_serial = (8'h7E >> i) & 8'h01;
      repeat (CPB) @(negedge PCLK);
    end
    rx_serial = 1'b1;
    repeat (50) @(negedge PCLK);
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    chk("midrst_data", rx_data, 0);
    chk("midrst_done", rx_done, 0);
    chk("midrst_err", rx_error, 0);
    chk("midrst_busy", rx_busy, 0);
    idle(400);
    chk("midrst_nodone", done_tot - d0, 0);
    chk("midrst_noerr", err_tot - e0, 0);
    model_data = 8'h00;
    apply(8'h42, 1'b1, 1'b1, 100, "post_rst");

    for (int k = 0; k < 30; k++) begin
      logic [7:0] rd;
      bit rs, re;
      int rg;
      rd = 8'($urandom);
      rs = ($urandom_range(0, 9) != 0);
      re = ($urandom_range(0, 7) != 0);
      rg = $urandom_range(0, 150);
      if (re && !rs && rg < 10) rg = 10;
      apply(rd, rs, re, rg, $sformatf("rnd%0d", k));
    end
    rx_en = 1'b1;
    idle(50);
    chk("end_idle", rx_busy, 0);
    chk("never_both", both_tot, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the custom APB UART IP; the downstream counterpart of UART_TX.
- Consumes the tx_serial line (or an external RX pin), deserialises 8N1 frames (1 start, DATA_BITS data LSB-first, 1 stop) and presents parallel bytes with a one-cycle done strobe.
- Detects framing errors and false starts.
- Sits between the pad/loopback and the APB register/FIFO layer, clocked by PCLK.

Parameters:
- BAUD_RATE, 9600, line bit rate; must match UART_TX.
- CLK_FREQ, 100_000_000, PCLK frequency in Hz.
- DATA_BITS, 8, data bits per frame (5..9).
- Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division; 10416 at defaults.
- Derived localparam HALF_BIT = CLKS_PER_BIT/2.

Ports:
- PCLK  input  1  system clock; sole clock.
- PRESETn  input  1  reset, synchronous, active-low.
- rx_en  input  1  receive enable; while low, no new frame is accepted.
- rx_serial  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last correctly received word; valid when rx_done pulses, held until the next good frame.
- rx_done  output  1  one-cycle pulse on a good frame (stop bit = 1).
- rx_error  output  1  one-cycle pulse on a framing error (stop bit = 0).
- rx_busy  output  1  high whenever FSM is not in IDLE.

Behaviour:
- Reset: sampled only on the PCLK rising edge with PRESETn=0.
  - Reset values: rx_data=0, rx_done=0, rx_error=0, rx_busy=0.
  - FSM=IDLE; counters=0; both synchroniser flops=1 (idle level).
  - Reset mid-frame aborts the frame immediately; no done or error is produced.
- Input sync: rx_serial passes through a 2-flop synchroniser to rx_s. All decisions use rx_s, so there is a 2-cycle pin-to-FSM latency.
- Counter: clk_cnt counts 0..CLKS_PER_BIT-1; bit_idx counts 0..DATA_BITS-1.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: if rx_en=1 and rx_s=0, go to START with clk_cnt=0.
- START: at clk_cnt==HALF_BIT-1, re-check the line.
  - rx_s=0: go to DATA with clk_cnt=0 and bit_idx=0.
  - rx_s=1: false start (glitch); return to IDLE with no strobe.
- DATA: at clk_cnt==CLKS_PER_BIT-1, shift rx_s into the shift register LSB-first (shreg <= {rx_s, shreg[DATA_BITS-1:1]}), then reset clk_cnt.
  - If bit_idx==DATA_BITS-1, go to STOP; otherwise increment bit_idx.
  - Each sample lands at the mid-point of its bit.
- STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: rx_data<=shreg, rx_done=1 for one cycle, go to IDLE.
  - rx_s=0: rx_error=1 for one cycle, rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition (line held low) from being re-detected as endless start bits.
- rx_done and rx_error are mutually exclusive and never asserted in the same cycle.
- Latency: rx_done is asserted 2 + HALF_BIT + (DATA_BITS+1)*CLKS_PER_BIT cycles (±1) after the rx_serial falling edge.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start bit immediately following the stop bit is caught with no lost frame.
- rx_en deasserted mid-frame: the current frame completes normally; only the next start detection is gated.
- rx_busy is registered and equals (state != IDLE).

Decomposition:
- Shared package/include uart_pkg holds:
  - state encodings (IDLE, START, DATA, STOP, WAIT_HIGH);
  - the clks_per_bit(CLK_FREQ, BAUD_RATE) function, also used by UART_TX so both sides agree on bit timing;
  - frame constants (START_BIT=0, STOP_BIT=1).
- One sub-module: uart_sync_2ff, a 2-flop synchroniser with reset value parameter RST_VAL=1 and synchronous active-low reset. It is reusable for any future async inputs.

Test Plan:
- Run all scenarios with BAUD_RATE=1_000_000 (100 clocks/bit) for speed.
- Loopback: UART_TX.tx_serial drives uart_rx.rx_serial; send 0x0F, 0xEE, 0xCD with idle gaps -> three rx_done pulses with rx_data=0x0F, 0xEE, 0xCD; rx_error never asserted.
- Back-to-back: send 0x55 then 0xA3 with zero idle between the stop bit and the next start bit -> two rx_done pulses, data 0x55 then 0xA3.
- Glitch: drive rx_serial low for 20 cycles (< HALF_BIT), then high -> FSM returns to IDLE, rx_busy drops, no rx_done or rx_error.
- Framing error: drive a frame with data 0x3C and stop bit=0, then hold low for 300 cycles, then high.
  - -> one rx_error pulse; rx_data keeps its previous value; FSM stays in WAIT_HIGH (rx_busy=1) until the line goes high.
  - -> no spurious frames while the line is held low.
- rx_en gating: with rx_en=0, send 0x81 -> no rx_done and rx_busy stays 0. Then set rx_en=1 and send 0x81 -> rx_done with rx_data=0x81.
- Reset mid-frame: assert PRESETn=0 for 2 cycles at bit 4 of frame 0x7E -> outputs reset to 0 and FSM is IDLE. A following 0x42 frame is received correctly.
